// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver FSM encoding, line levels and the bit-vote helper.
package uart_pkg;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_START     = 3'd1,
    ST_DATA      = 3'd2,
    ST_PARITY    = 3'd3,
    ST_STOP      = 3'd4,
    ST_WAIT_HIGH = 3'd5
  } uart_state_e;

  localparam logic IDLE_LEVEL  = 1'b1;
  localparam logic START_LEVEL = 1'b0;
  localparam logic STOP_LEVEL  = 1'b1;

  function automatic logic majority3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// Oversampling tick generator: one-clock pulse every DIV clocks while enabled; clr restarts the phase.
module uart_baud_tick #(
  parameter int unsigned DIV = 1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  input  logic clr,
  output logic tick
);

  localparam int unsigned CW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(DIV - 1);

  logic [CW-1:0] cnt_q, cnt_d;
  logic          tick_q, tick_d;

  always_comb begin
    cnt_d  = cnt_q;
    tick_d = 1'b0;
    if (clr) begin
      cnt_d = '0;
    end else if (en) begin
      if (cnt_q == LAST) begin
        cnt_d  = '0;
        tick_d = 1'b1;
      end else begin
        cnt_d = cnt_q + CW'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q  <= '0;
      tick_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      tick_q <= tick_d;
    end
  end

  assign tick = tick_q;

endmodule

// File: rtl/uart_rx_oversampled.sv
// 8N1 UART receiver with oversampled 3-sample majority voting and a valid/ready holding register.
// Optional even-parity bit and parity_err output enabled by defining UART_RX_PARITY_EN.
module uart_rx_oversampled
  import uart_pkg::*;
#(
  parameter int unsigned CLK_FREQ   = 100_000_000,
  parameter int unsigned BAUD_RATE  = 115_200,
  parameter int unsigned OVERSAMPLE = 16,
  parameter int unsigned DATA_BITS  = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 rx,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_valid,
  input  logic                 rx_ready,
  output logic                 frame_err,
  output logic                 overrun,
`ifdef UART_RX_PARITY_EN
  output logic                 parity_err,
`endif
  output logic                 busy
);

  localparam int unsigned TICK_RAW = CLK_FREQ / (BAUD_RATE * OVERSAMPLE);
  localparam int unsigned TICK_DIV = (TICK_RAW < 1) ? 1 : TICK_RAW;
  localparam int unsigned OSW      = $clog2(OVERSAMPLE);
  localparam int unsigned IDXW     = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;

  localparam logic [OSW-1:0]  SAMP0    = OSW'(OVERSAMPLE / 2 - 1);
  localparam logic [OSW-1:0]  SAMP1    = OSW'(OVERSAMPLE / 2);
  localparam logic [OSW-1:0]  SAMP2    = OSW'(OVERSAMPLE / 2 + 1);
  localparam logic [OSW-1:0]  OS_LAST  = OSW'(OVERSAMPLE - 1);
  localparam logic [IDXW-1:0] IDX_LAST = IDXW'(DATA_BITS - 1);

  uart_state_e state_q, state_d;

  logic                 rx_meta_q, rx_sync_q;
  logic [OSW-1:0]       os_cnt_q, os_cnt_d;
  logic [IDXW-1:0]      bit_idx_q, bit_idx_d;
  logic                 samp0_q, samp0_d, samp1_q, samp1_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic [DATA_BITS-1:0] data_q, data_d;
  logic                 valid_q, valid_d;
  logic                 frame_err_q, frame_err_d;
  logic                 overrun_q, overrun_d;
  logic                 busy_q, busy_d;
  logic                 par_bit_q, par_bit_d;
  logic                 par_err_q, par_err_d;

  logic tick, decide_c, bit_end_c, bit_val_c, frame_good_c;

  uart_baud_tick #(.DIV(TICK_DIV)) u_tick (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (state_q != ST_IDLE),
    .clr   (state_q == ST_IDLE),
    .tick  (tick)
  );

  assign decide_c     = tick && (os_cnt_q == SAMP2);
  assign bit_end_c    = tick && (os_cnt_q == OS_LAST);
  assign bit_val_c    = majority3(samp0_q, samp1_q, rx_sync_q);
  assign frame_good_c = (state_q == ST_STOP) && decide_c && (bit_val_c == STOP_LEVEL);

  // Two-flop synchronizer; the line idles high so the flops reset to the idle level.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_meta_q <= IDLE_LEVEL;
      rx_sync_q <= IDLE_LEVEL;
    end else begin
      rx_meta_q <= rx;
      rx_sync_q <= rx_meta_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  // Stop is resolved at mid-bit so the next start edge can be caught early.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:      if (rx_sync_q == START_LEVEL) state_d = ST_START;
      ST_START: begin
        if (decide_c && (bit_val_c == IDLE_LEVEL)) state_d = ST_IDLE;
        else if (bit_end_c)                        state_d = ST_DATA;
      end
      ST_DATA: begin
        if (bit_end_c && (bit_idx_q == IDX_LAST)) begin
`ifdef UART_RX_PARITY_EN
          state_d = ST_PARITY;
`else
          state_d = ST_STOP;
`endif
        end
      end
`ifdef UART_RX_PARITY_EN
      ST_PARITY:    if (bit_end_c) state_d = ST_STOP;
`endif
      ST_STOP:      if (decide_c) state_d = (bit_val_c == STOP_LEVEL) ? ST_IDLE : ST_WAIT_HIGH;
      ST_WAIT_HIGH: if (rx_sync_q == IDLE_LEVEL) state_d = ST_IDLE;
      default:      state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    os_cnt_d    = os_cnt_q;
    bit_idx_d   = bit_idx_q;
    samp0_d     = samp0_q;
    samp1_d     = samp1_q;
    shift_d     = shift_q;
    par_bit_d   = par_bit_q;
    data_d      = data_q;
    valid_d     = valid_q;
    par_err_d   = par_err_q;
    frame_err_d = 1'b0;
    overrun_d   = 1'b0;
    busy_d      = (state_d != ST_IDLE);

    if (state_q == ST_IDLE)  os_cnt_d = '0;
    else if (tick)           os_cnt_d = (os_cnt_q == OS_LAST) ? '0 : os_cnt_q + OSW'(1);
    if (tick && (os_cnt_q == SAMP0)) samp0_d = rx_sync_q;
    if (tick && (os_cnt_q == SAMP1)) samp1_d = rx_sync_q;

    if (state_q == ST_START)                bit_idx_d = '0;
    if ((state_q == ST_DATA) && bit_end_c)  bit_idx_d = bit_idx_q + IDXW'(1);
    if ((state_q == ST_DATA) && decide_c)   shift_d   = {bit_val_c, shift_q[DATA_BITS-1:1]};
    if ((state_q == ST_PARITY) && decide_c) par_bit_d = bit_val_c;

    if ((state_q == ST_STOP) && decide_c && (bit_val_c != STOP_LEVEL)) frame_err_d = 1'b1;

    // A good frame may load in the same clock the old byte is accepted.
    if (frame_good_c) begin
      if (!valid_q || rx_ready) begin
        data_d    = shift_q;
        valid_d   = 1'b1;
        par_err_d = (^shift_q) ^ par_bit_q;
      end else begin
        overrun_d = 1'b1;
      end
    end else if (valid_q && rx_ready) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      os_cnt_q    <= '0;
      bit_idx_q   <= '0;
      samp0_q     <= IDLE_LEVEL;
      samp1_q     <= IDLE_LEVEL;
      shift_q     <= '0;
      par_bit_q   <= 1'b0;
      data_q      <= '0;
      valid_q     <= 1'b0;
      par_err_q   <= 1'b0;
      frame_err_q <= 1'b0;
      overrun_q   <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      os_cnt_q    <= os_cnt_d;
      bit_idx_q   <= bit_idx_d;
      samp0_q     <= samp0_d;
      samp1_q     <= samp1_d;
      shift_q     <= shift_d;
      par_bit_q   <= par_bit_d;
      data_q      <= data_d;
      valid_q     <= valid_d;
      par_err_q   <= par_err_d;
      frame_err_q <= frame_err_d;
      overrun_q   <= overrun_d;
      busy_q      <= busy_d;
    end
  end

  assign rx_data   = data_q;
  assign rx_valid  = valid_q;
  assign frame_err = frame_err_q;
  assign overrun   = overrun_q;
  assign busy      = busy_q;
`ifdef UART_RX_PARITY_EN
  assign parity_err = par_err_q;
`else
  logic unused_par;
  assign unused_par = par_err_q ^ par_bit_q;
`endif

endmodule

// File: tb/tb_uart_rx_oversampled.sv
// Self-checking bench for uart_rx_oversampled at 160 clocks per bit; define UART_RX_PARITY_EN to test parity.
module tb_uart_rx_oversampled;

  localparam int unsigned BIT_CLKS = 160;

  logic       clk = 1'b0;
  logic       rst_n, rx, rx_ready;
  logic [7:0] rx_data;
  logic       rx_valid, frame_err, overrun, busy;
`ifdef UART_RX_PARITY_EN
  logic       parity_err;
`endif

  uart_rx_oversampled #(
    .CLK_FREQ(1_600_000), .BAUD_RATE(10_000), .OVERSAMPLE(16), .DATA_BITS(8)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .rx        (rx),
    .rx_data   (rx_data),
    .rx_valid  (rx_valid),
    .rx_ready  (rx_ready),
    .frame_err (frame_err),
    .overrun   (overrun),
`ifdef UART_RX_PARITY_EN
    .parity_err(parity_err),
`endif
    .busy      (busy)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int fe_cnt = 0, ov_cnt = 0, rise_cyc = 0, t_start = 0;
  logic prev_valid = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  // Event monitor: counts pulses and timestamps each rx_valid rise.
  always @(negedge clk) begin
    prev_valid <= rx_valid;
    if (rx_valid && !prev_valid) rise_cyc <= cyc;
    if (frame_err) fe_cnt <= fe_cnt + 1;
    if (overrun)   ov_cnt <= ov_cnt + 1;
  end

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout required completion");
    $fatal(1);
  end

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic drive_bit(input logic v, input int glitch_pos);
    rx = v;
    if (glitch_pos < 0) begin
      repeat (BIT_CLKS) @(negedge clk);
    end else begin
      repeat (glitch_pos) @(negedge clk);
      rx = ~v;
      @(negedge clk);
      rx = v;
      repeat (BIT_CLKS - glitch_pos - 1) @(negedge clk);
    end
  endtask

  task automatic send_frame(input logic [7:0] d, input logic stop, input int glitch_bit,
                            input logic par, input int low_after);
    t_start = cyc;
    drive_bit(1'b0, -1);
    for (int i = 0; i < 8; i++) drive_bit(d[i], (i == glitch_bit) ? 90 : -1);
`ifdef UART_RX_PARITY_EN
    drive_bit(par, -1);
`else
    if (par === 1'bx) rx = 1'b1;
`endif
    drive_bit(stop, -1);
    for (int i = 0; i < low_after; i++) drive_bit(1'b0, -1);
    rx = 1'b1;
  endtask

  task automatic drain(output logic [7:0] d, output logic v);
    v = rx_valid;
    d = rx_data;
    rx_ready = 1'b1;
    @(negedge clk);
    rx_ready = 1'b0;
  endtask

  typedef struct {
    logic [7:0] data;
    logic       stop;
    logic       exp_valid;
    logic [7:0] exp_data;
    int         exp_fe;
  } vec_t;

  vec_t tbl[5];

  initial begin
    logic [7:0] gd, md, d;
    logic       gv, mv, bad;
    int         fe0, ov0, lat, exp_fe, exp_ov;

    tbl[0] = '{8'hA5, 1'b1, 1'b1, 8'hA5, 0};
    tbl[1] = '{8'h3C, 1'b0, 1'b0, 8'h00, 1};
    tbl[2] = '{8'h81, 1'b1, 1'b1, 8'h81, 0};
    tbl[3] = '{8'h00, 1'b1, 1'b1, 8'h00, 0};
    tbl[4] = '{8'hFF, 1'b1, 1'b1, 8'hFF, 0};

    rst_n = 1'b0; rx = 1'b1; rx_ready = 1'b0;
    idle(5);
    check("rst_valid", rx_valid, 0);
    check("rst_data", rx_data, 0);
    check("rst_busy", busy, 0);
    check("rst_frame_err", frame_err, 0);
    check("rst_overrun", overrun, 0);
    rst_n = 1'b1;
    idle(20);

    // Table: single frames with the holding register emptied first.
    for (int i = 0; i < 5; i++) begin
      drain(gd, gv);
      fe0 = fe_cnt;
      send_frame(tbl[i].data, tbl[i].stop, -1, ^tbl[i].data, 0);
      idle(20);
      check($sformatf("tbl%0d_valid", i), rx_valid, tbl[i].exp_valid);
      if (tbl[i].exp_valid) check($sformatf("tbl%0d_data", i), rx_data, tbl[i].exp_data);
      check($sformatf("tbl%0d_fe", i), fe_cnt - fe0, tbl[i].exp_fe);
    end

    // Latency and hold with rx_ready low.
    drain(gd, gv);
    send_frame(8'hA5, 1'b1, -1, 1'b0, 0);
    idle(300);
    lat = rise_cyc - t_start;
    check("latency_window", int'(lat >= 1500 && lat <= 1580), 1);
    check("hold_valid", rx_valid, 1);
    check("hold_data", rx_data, 8'hA5);

    // False start: 30-clock low pulse.
    drain(gd, gv);
    fe0 = fe_cnt;
    rx = 1'b0;
    idle(10);
    check("false_busy_hi", busy, 1);
    idle(20);
    rx = 1'b1;
    idle(BIT_CLKS);
    check("false_busy_lo", busy, 0);
    check("false_valid", rx_valid, 0);
    check("false_fe", fe_cnt - fe0, 0);

    // Bad stop followed by a long low line, then a clean frame.
    fe0 = fe_cnt;
    send_frame(8'h3C, 1'b0, -1, ^8'h3C, 5);
    idle(BIT_CLKS);
    check("brk_fe", fe_cnt - fe0, 1);
    check("brk_valid", rx_valid, 0);
    send_frame(8'h81, 1'b1, -1, ^8'h81, 0);
    idle(20);
    check("brk_next_data", rx_data, 8'h81);
    check("brk_next_valid", rx_valid, 1);
    check("brk_fe_once", fe_cnt - fe0, 1);

    // Overrun: second byte dropped, first kept.
    drain(gd, gv);
    ov0 = ov_cnt;
    send_frame(8'h11, 1'b1, -1, ^8'h11, 0);
    send_frame(8'h22, 1'b1, -1, ^8'h22, 0);
    idle(20);
    check("ovr_count", ov_cnt - ov0, 1);
    check("ovr_data", rx_data, 8'h11);
    drain(gd, gv);
    check("ovr_drain", gd, 8'h11);
    check("ovr_empty", rx_valid, 0);

    // Single-clock glitch near mid-bit is outvoted.
    send_frame(8'hFF, 1'b1, 3, ^8'hFF, 0);
    idle(20);
    check("glitch_data", rx_data, 8'hFF);
    check("glitch_valid", rx_valid, 1);

    // Reset mid-data with a full holding register.
    d = 8'h55;
    drive_bit(1'b0, -1);
    for (int i = 0; i < 4; i++) drive_bit(d[i], -1);
    rst_n = 1'b0;
    idle(3);
    check("mrst_valid", rx_valid, 0);
    check("mrst_data", rx_data, 0);
    check("mrst_busy", busy, 0);
    check("mrst_fe", frame_err, 0);
    for (int i = 4; i < 8; i++) drive_bit(d[i], (i == 4) ? -1 : -1);
    drive_bit(1'b1, -1);
    rst_n = 1'b1;
    idle(BIT_CLKS);
    check("mrst_nodeliver", rx_valid, 0);
    send_frame(8'h0F, 1'b1, -1, ^8'h0F, 0);
    idle(20);
    check("mrst_next", rx_data, 8'h0F);
    check("mrst_next_valid", rx_valid, 1);

`ifdef UART_RX_PARITY_EN
    drain(gd, gv);
    send_frame(8'h07, 1'b1, -1, 1'b0, 0);
    idle(20);
    check("par_bad_data", rx_data, 8'h07);
    check("par_bad_err", parity_err, 1);
    drain(gd, gv);
    send_frame(8'h07, 1'b1, -1, 1'b1, 0);
    idle(20);
    check("par_ok_err", parity_err, 0);
`endif

    // Random frames against a holding-register reference model.
    drain(gd, gv);
    mv = 1'b0; md = 8'h00;
    exp_fe = 0; exp_ov = 0;
    fe0 = fe_cnt; ov0 = ov_cnt;
    for (int n = 0; n < 14; n++) begin
      d   = 8'($urandom);
      bad = ($urandom_range(0, 4) == 0);
      send_frame(d, ~bad, -1, ^d, 0);
      idle(5);
      if (bad)     exp_fe++;
      else if (mv) exp_ov++;
      else begin mv = 1'b1; md = d; end
      if ($urandom_range(0, 1) == 1) begin
        drain(gd, gv);
        check("rnd_valid", gv, mv);
        if (mv) check("rnd_data", gd, md);
        mv = 1'b0;
      end
    end
    idle(5);
    check("rnd_fe_total", fe_cnt - fe0, exp_fe);
    check("rnd_ov_total", ov_cnt - ov0, exp_ov);
    check("rnd_final_valid", rx_valid, mv);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
